// File: rtl/pps_timestamp_pkg.sv
// Shared register map, bit positions and widths for the PPS timestamp peripheral.
package pps_timestamp_pkg;

  localparam int TS_W = 32;

  localparam logic [7:0] REG_STATUS  = 8'h00;
  localparam logic [7:0] REG_DATA    = 8'h04;
  localparam logic [7:0] REG_CTRL    = 8'h08;
  localparam logic [7:0] REG_COUNTER = 8'h0C;

  localparam int STATUS_OVF_BIT   = 8;
  localparam int STATUS_IRQEN_BIT = 9;
  localparam int CTRL_IRQEN_BIT   = 0;
  localparam int CTRL_OVFCLR_BIT  = 1;

  function automatic logic [31:0] statusWord(input logic [7:0] fillCount,
                                             input logic overflow,
                                             input logic irqEnable);
    logic [31:0] w;
    w = '0;
    w[7:0] = fillCount;
    w[STATUS_OVF_BIT] = overflow;
    w[STATUS_IRQEN_BIT] = irqEnable;
    return w;
  endfunction

endpackage

// File: rtl/pps_ts_fifo.sv
// Small synchronous capture FIFO; a pop on empty is ignored and a push while full
// only lands when a pop frees the slot in the same cycle.
module pps_ts_fifo
  import pps_timestamp_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push_i,
  input  logic [TS_W-1:0]          pushData_i,
  input  logic                     pop_i,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   count_o,
  output logic [TS_W-1:0]          head_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  logic [TS_W-1:0] mem_q [DEPTH];
  logic [AW-1:0]   wrPtr_q, rdPtr_q;
  logic [CW-1:0]   count_q, count_d;
  logic            doPush, doPop;

  always_comb begin
    doPop   = pop_i && (count_q != '0);
    doPush  = push_i && ((count_q != FULL_CNT) || doPop);
    count_d = count_q;
    if (doPush && !doPop) count_d = count_q + CW'(1);
    if (doPop && !doPush) count_d = count_q - CW'(1);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wrPtr_q <= '0;
      rdPtr_q <= '0;
      count_q <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      if (doPush) begin
        mem_q[wrPtr_q] <= pushData_i;
        wrPtr_q <= wrPtr_q + AW'(1);
      end
      if (doPop) rdPtr_q <= rdPtr_q + AW'(1);
      count_q <= count_d;
    end
  end

  assign full_o  = (count_q == FULL_CNT);
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign head_o  = mem_q[rdPtr_q];

endmodule

// File: rtl/pps_timestamp.sv
// Memory-mapped PPS timestamp capture: free-running cycle counter sampled on each
// synchronized PPS rising edge, queued in a FIFO and drained by firmware over iomem.
module pps_timestamp
  import pps_timestamp_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR  = 32'h0300_0000,
  parameter int          FIFO_DEPTH = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        iomem_valid,
  output logic        iomem_ready,
  input  logic [3:0]  iomem_wstrb,
  input  logic [31:0] iomem_addr,
  input  logic [31:0] iomem_wdata,
  output logic [31:0] iomem_rdata,
  input  logic        pps_in,
  output logic        irq
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  logic [TS_W-1:0] counter_q, counter_d;
  logic            ppsMeta_q, ppsSync_q, ppsPrev_q;
  logic [1:0]      prime_q, prime_d;
  logic            ready_q, ready_d;
  logic [31:0]     rdata_q, rdata_d;
  logic            irqEn_q, irqEn_d;
  logic            ovf_q, ovf_d;
  logic            irq_q, irq_d;

  logic            sel, ack, rdAck, wrAck, ppsEdge;
  logic [7:0]      regOff;
  logic            fifoPop, fifoFull, fifoEmpty;
  logic [CW-1:0]   fifoCount;
  logic [TS_W-1:0] fifoHead;
  logic            unused_wdata;

  assign unused_wdata = ^iomem_wdata[31:2];

  pps_ts_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk        (clk),
    .reset      (reset),
    .push_i     (ppsEdge),
    .pushData_i (counter_q),
    .pop_i      (fifoPop),
    .full_o     (fifoFull),
    .empty_o    (fifoEmpty),
    .count_o    (fifoCount),
    .head_o     (fifoHead)
  );

  // The prime counter blanks edge detection until the prev flop holds a real pin
  // sample, so a pin already high at reset release is not seen as a rising edge.
  always_comb begin
    sel     = iomem_valid && (iomem_addr[31:8] == BASE_ADDR[31:8]);
    ack     = sel && !ready_q;
    rdAck   = ack && (iomem_wstrb == 4'b0000);
    wrAck   = ack && (iomem_wstrb != 4'b0000);
    regOff  = iomem_addr[7:0];
    ppsEdge = ppsSync_q && !ppsPrev_q && (prime_q == 2'd3);
    fifoPop = rdAck && (regOff == REG_DATA);

    counter_d = counter_q + TS_W'(1);
    prime_d   = (prime_q == 2'd3) ? prime_q : prime_q + 2'd1;
    ready_d   = ack;
    irqEn_d   = irqEn_q;
    ovf_d     = ovf_q;
    rdata_d   = '0;

    if (wrAck && (regOff == REG_CTRL)) begin
      if (iomem_wstrb[0]) irqEn_d = iomem_wdata[CTRL_IRQEN_BIT];
      if (iomem_wdata[CTRL_OVFCLR_BIT]) ovf_d = 1'b0;
    end
    if (ppsEdge && fifoFull && !fifoPop) ovf_d = 1'b1;

    if (rdAck) begin
      case (regOff)
        REG_STATUS:  rdata_d = statusWord({{(8-CW){1'b0}}, fifoCount}, ovf_q, irqEn_q);
        REG_DATA:    rdata_d = fifoEmpty ? '0 : fifoHead;
        REG_CTRL:    rdata_d = {30'b0, 1'b0, irqEn_q};
        REG_COUNTER: rdata_d = counter_d;
        default:     rdata_d = '0;
      endcase
    end

    irq_d = irqEn_q && (fifoCount != '0);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      counter_q <= '0;
      ppsMeta_q <= 1'b0;
      ppsSync_q <= 1'b0;
      ppsPrev_q <= 1'b0;
      prime_q   <= '0;
      ready_q   <= 1'b0;
      rdata_q   <= '0;
      irqEn_q   <= 1'b0;
      ovf_q     <= 1'b0;
      irq_q     <= 1'b0;
    end else begin
      counter_q <= counter_d;
      ppsMeta_q <= pps_in;
      ppsSync_q <= ppsMeta_q;
      ppsPrev_q <= ppsSync_q;
      prime_q   <= prime_d;
      ready_q   <= ready_d;
      rdata_q   <= rdata_d;
      irqEn_q   <= irqEn_d;
      ovf_q     <= ovf_d;
      irq_q     <= irq_d;
    end
  end

  assign iomem_ready = ready_q;
  assign iomem_rdata = rdata_q;
  assign irq         = irq_q;

endmodule

// File: tb/tb_pps_timestamp.sv
// Self-checking bench for pps_timestamp: register-map vector table plus hand-written
// capture, overflow, push/pop collision, interrupt and bus corner-case sequences.
module tb_pps_timestamp;
  import pps_timestamp_pkg::*;

  localparam logic [31:0] BASE  = 32'h0300_0000;
  localparam int          DEPTH = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        iomem_valid = 1'b0;
  logic [3:0]  iomem_wstrb = 4'h0;
  logic [31:0] iomem_addr = 32'h0;
  logic [31:0] iomem_wdata = 32'h0;
  logic        iomem_ready;
  logic [31:0] iomem_rdata;
  logic        pps_in = 1'b0;
  logic        irq;

  int          nChecks = 0;
  int          nFails = 0;
  logic [31:0] mcnt;
  logic [31:0] modelQ[$];
  logic        modelOvf = 1'b0;
  logic        modelIrqEn = 1'b0;
  logic [31:0] expVal[$];
  string       expName[$];
  logic        lastAckIrq;

  typedef struct packed {
    logic [7:0]  off;
    logic [3:0]  wstrb;
    logic [31:0] wdata;
    logic        checkRd;
    logic [31:0] expRd;
  } vec_t;

  vec_t vecs[15];

  pps_timestamp #(.BASE_ADDR(BASE), .FIFO_DEPTH(DEPTH)) dut (
    .clk         (clk),
    .reset       (reset),
    .iomem_valid (iomem_valid),
    .iomem_ready (iomem_ready),
    .iomem_wstrb (iomem_wstrb),
    .iomem_addr  (iomem_addr),
    .iomem_wdata (iomem_wdata),
    .iomem_rdata (iomem_rdata),
    .pps_in      (pps_in),
    .irq         (irq)
  );

  always #5 clk = ~clk;

  // Reference cycle counter: zero in reset, +1 on every clock afterwards.
  always @(posedge clk or posedge reset) begin
    if (reset) mcnt <= 32'h0;
    else       mcnt <= mcnt + 32'h1;
  end

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout, required completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    nChecks++;
    if (actual !== expected) begin
      nFails++;
      $display("[TB] FAIL %s: got 0x%08h, required 0x%08h", name, actual, expected);
    end
  endtask

  // Called at a negedge; drives the request, waits for the ack, then idles one cycle.
  task automatic busXfer(input logic [31:0] addr, input logic [3:0] wstrb,
                         input logic [31:0] wdata, output logic [31:0] rd);
    bit acked;
    acked = 1'b0;
    rd = '0;
    iomem_valid = 1'b1;
    iomem_addr  = addr;
    iomem_wstrb = wstrb;
    iomem_wdata = wdata;
    for (int i = 0; i < 8 && !acked; i++) begin
      @(negedge clk);
      if (iomem_ready) begin
        acked = 1'b1;
        rd = iomem_rdata;
        lastAckIrq = irq;
      end
    end
    iomem_valid = 1'b0;
    iomem_wstrb = 4'h0;
    if (!acked) begin
      nChecks++;
      nFails++;
      $display("[TB] FAIL ack_timeout: addr 0x%08h got no ready, required ready within 8 cycles", addr);
    end
    @(negedge clk);
  endtask

  task automatic readExp(input logic [7:0] off, input logic [31:0] exp, input string name);
    logic [31:0] rd;
    expVal.push_back(exp);
    expName.push_back(name);
    busXfer(BASE | {24'h0, off}, 4'h0, 32'h0, rd);
    checkOutput(expName.pop_front(), rd, expVal.pop_front());
  endtask

  task automatic writeReg(input logic [7:0] off, input logic [3:0] strb, input logic [31:0] data);
    logic [31:0] rd;
    busXfer(BASE | {24'h0, off}, strb, data, rd);
  endtask

  task automatic applyStimulus(input vec_t v, input int idx);
    if (v.checkRd) readExp(v.off, v.expRd, $sformatf("vec%0d_off%02h", idx, v.off));
    else           writeReg(v.off, v.wstrb, v.wdata);
  endtask

  task automatic readStatus(input string name);
    readExp(REG_STATUS, statusWord(8'(modelQ.size()), modelOvf, modelIrqEn), name);
  endtask

  task automatic readData(input string name);
    logic [31:0] exp;
    exp = (modelQ.size() != 0) ? modelQ.pop_front() : 32'h0;
    readExp(REG_DATA, exp, name);
  endtask

  task automatic readCounter(input string name);
    readExp(REG_COUNTER, mcnt + 32'h1, name);
  endtask

  task automatic modelCapture(input logic [31:0] value);
    if (modelQ.size() < DEPTH) modelQ.push_back(value);
    else                       modelOvf = 1'b1;
  endtask

  // Pin rises during the cycle whose counter is mcnt; capture lands two cycles later.
  task automatic ppsPulse();
    pps_in = 1'b1;
    modelCapture(mcnt + 32'h2);
    repeat (3) @(negedge clk);
    pps_in = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  initial begin
    logic [31:0] cap;
    logic [3:0]  pattern;
    int          readyCount;
    logic [31:0] rdataOr;
    logic        irqSeen;

    vecs[0]  = '{REG_STATUS,  4'h0, 32'h0,         1'b1, 32'h0};
    vecs[1]  = '{REG_CTRL,    4'h0, 32'h0,         1'b1, 32'h0};
    vecs[2]  = '{8'h10,       4'h0, 32'h0,         1'b1, 32'h0};
    vecs[3]  = '{8'hFC,       4'h0, 32'h0,         1'b1, 32'h0};
    vecs[4]  = '{REG_STATUS,  4'hF, 32'hFFFF_FFFF, 1'b0, 32'h0};
    vecs[5]  = '{REG_STATUS,  4'h0, 32'h0,         1'b1, 32'h0};
    vecs[6]  = '{REG_CTRL,    4'h1, 32'h1,         1'b0, 32'h0};
    vecs[7]  = '{REG_CTRL,    4'h0, 32'h0,         1'b1, 32'h1};
    vecs[8]  = '{REG_STATUS,  4'h0, 32'h0,         1'b1, 32'h200};
    vecs[9]  = '{REG_CTRL,    4'h2, 32'h0,         1'b0, 32'h0};
    vecs[10] = '{REG_CTRL,    4'h0, 32'h0,         1'b1, 32'h1};
    vecs[11] = '{REG_CTRL,    4'h1, 32'h0,         1'b0, 32'h0};
    vecs[12] = '{REG_CTRL,    4'h0, 32'h0,         1'b1, 32'h0};
    vecs[13] = '{REG_DATA,    4'h0, 32'h0,         1'b1, 32'h0};
    vecs[14] = '{REG_STATUS,  4'h0, 32'h0,         1'b1, 32'h0};

    // Reset state
    repeat (3) @(negedge clk);
    checkOutput("reset_ready", {31'h0, iomem_ready}, 32'h0);
    checkOutput("reset_rdata", iomem_rdata, 32'h0);
    checkOutput("reset_irq", {31'h0, irq}, 32'h0);
    reset = 1'b0;
    repeat (11) @(negedge clk);
    $display("[TB] counter checks");
    readCounter("counter_after_reset");
    readCounter("counter_second_read");

    $display("[TB] register map vectors");
    for (int i = 0; i < 15; i++) applyStimulus(vecs[i], i);

    $display("[TB] single capture");
    ppsPulse();
    readStatus("single_status_one");
    readData("single_data");
    readStatus("single_status_empty");

    $display("[TB] overflow");
    for (int i = 0; i < 6; i++) ppsPulse();
    readStatus("ovf_status_104");
    for (int i = 0; i < 4; i++) readData($sformatf("ovf_data%0d", i));
    readStatus("ovf_status_100");
    writeReg(REG_CTRL, 4'h1, 32'h2);
    modelOvf = 1'b0;
    readStatus("ovf_cleared");

    $display("[TB] simultaneous push and pop");
    for (int i = 0; i < 4; i++) ppsPulse();
    readStatus("sim_full_status");
    pps_in = 1'b1;
    cap = mcnt + 32'h2;
    repeat (2) @(negedge clk);
    readData("sim_pop_oldest");
    modelQ.push_back(cap);
    pps_in = 1'b0;
    repeat (4) @(negedge clk);
    readStatus("sim_status_after");
    for (int i = 0; i < 4; i++) readData($sformatf("sim_drain%0d", i));

    $display("[TB] interrupt");
    writeReg(REG_CTRL, 4'h1, 32'h1);
    modelIrqEn = 1'b1;
    pps_in = 1'b1;
    modelCapture(mcnt + 32'h2);
    repeat (3) @(negedge clk);
    checkOutput("irq_low_at_push", {31'h0, irq}, 32'h0);
    @(negedge clk);
    checkOutput("irq_high_after_push", {31'h0, irq}, 32'h1);
    pps_in = 1'b0;
    repeat (4) @(negedge clk);
    readStatus("irq_status");
    readData("irq_data");
    checkOutput("irq_held_in_ack", {31'h0, lastAckIrq}, 32'h1);
    checkOutput("irq_low_after_pop", {31'h0, irq}, 32'h0);
    writeReg(REG_CTRL, 4'h1, 32'h0);
    modelIrqEn = 1'b0;
    irqSeen = 1'b0;
    pps_in = 1'b1;
    modelCapture(mcnt + 32'h2);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (i == 3) pps_in = 1'b0;
      irqSeen = irqSeen | irq;
    end
    checkOutput("irq_disabled", {31'h0, irqSeen}, 32'h0);
    readData("irq_dis_data");

    $display("[TB] bus corner cases");
    readData("empty_data_read");
    readStatus("empty_status");

    readyCount = 0;
    rdataOr = 32'h0;
    iomem_valid = 1'b1;
    iomem_addr = BASE + 32'h100;
    iomem_wstrb = 4'h0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (iomem_ready) readyCount++;
      rdataOr = rdataOr | iomem_rdata;
    end
    iomem_valid = 1'b0;
    @(negedge clk);
    checkOutput("outside_window_ready", 32'(readyCount), 32'h0);
    checkOutput("outside_window_rdata", rdataOr, 32'h0);

    pattern = 4'h0;
    iomem_valid = 1'b1;
    iomem_addr = BASE | {24'h0, REG_STATUS};
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      pattern[i] = iomem_ready;
    end
    iomem_valid = 1'b0;
    @(negedge clk);
    checkOutput("held4_ready_pattern", {28'h0, pattern}, 32'h5);

    $display("[TB] reset during request");
    pps_in = 1'b1;
    iomem_valid = 1'b1;
    iomem_addr = BASE | {24'h0, REG_COUNTER};
    #2 reset = 1'b1;
    readyCount = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (iomem_ready) readyCount++;
    end
    iomem_valid = 1'b0;
    modelQ.delete();
    modelOvf = 1'b0;
    modelIrqEn = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (iomem_ready) readyCount++;
    end
    checkOutput("reset_abandons_ack", 32'(readyCount), 32'h0);
    readStatus("pps_high_at_release");
    pps_in = 1'b0;
    repeat (4) @(negedge clk);
    ppsPulse();
    readData("capture_after_reset");

    $display("[TB] End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule
